// File: rtl/i2c_cmd_queue.sv
// i2c_cmd_queue: FIFO-buffered command sequencer in front of i2c_top; define I2C_RETRY_EN to re-issue NACKed commands
module i2c_cmd_queue #(
   parameter int DEPTH     = 4,
   parameter int RETRY_MAX = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic                     cmd_op,
   input  logic [6:0]               cmd_addr,
   input  logic [7:0]               cmd_data,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic                     rsp_op,
   output logic [7:0]               rsp_data,
   output logic                     rsp_err,
   output logic                     m_newd,
   output logic                     m_op,
   output logic [6:0]               m_addr,
   output logic [7:0]               m_din,
   input  logic [7:0]               m_dout,
   input  logic                     m_busy,
   input  logic                     m_ack_err,
   input  logic                     m_done,
   output logic [$clog2(DEPTH):0]   q_count,
   output logic                     idle
);
   localparam int AW = $clog2(DEPTH);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, RESP} state_t;
   state_t          state_q, state_d;
   logic [15:0]     mem_q [DEPTH];
   logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [AW:0]     count_q;
   logic            done_prev_q;
   logic            m_op_q, rsp_op_q, rsp_err_q;
   logic [6:0]      m_addr_q;
   logic [7:0]      m_din_q, rsp_data_q;
   logic            push, pop, done_rise, retry;
   assign cmd_ready = count_q != (AW+1)'(DEPTH);
   assign push      = cmd_valid & cmd_ready;
   assign pop       = (state_q == IDLE) && (count_q != '0);
   assign done_rise = m_done & ~done_prev_q;
   assign m_newd    = state_q == ISSUE;
   assign rsp_valid = state_q == RESP;
   assign idle      = (state_q == IDLE) && (count_q == '0);
   assign q_count   = count_q;
   assign m_op      = m_op_q;
   assign m_addr    = m_addr_q;
   assign m_din     = m_din_q;
   assign rsp_op    = rsp_op_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_err   = rsp_err_q;
`ifdef I2C_RETRY_EN
   localparam int RW = $clog2(RETRY_MAX + 2);
   logic [RW-1:0] retry_q;
   // Count re-issues of the current command; cleared whenever a new command is popped
   always_ff @(posedge clk or negedge rst)
      if (!rst) retry_q <= '0;
      else if (pop) retry_q <= '0;
      else if (retry) retry_q <= retry_q + RW'(1);
   // A NACK with attempts left sends the same command back out
   always_comb begin
      retry = 1'b0;
      if (state_q == WAIT_DONE && done_rise && m_ack_err && retry_q < RW'(RETRY_MAX)) retry = 1'b1;
   end
`else
   assign retry = 1'b0;
`endif
   // Command storage; contents need no reset since occupancy is tracked separately
   always_ff @(posedge clk)
      if (push) mem_q[wr_ptr_q] <= {cmd_op, cmd_addr, cmd_data};
   // FIFO pointers and occupancy; simultaneous push and pop leave the count unchanged
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q <= count_q + (AW+1)'(push) - (AW+1)'(pop);
      end
   // State register plus registered done level for edge detection
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state_q     <= IDLE;
         done_prev_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         done_prev_q <= m_done;
      end
   // Sequencer: issue one command, wait for its completion, hand back the response
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:      if (pop) state_d = ISSUE;
         ISSUE:     if (m_busy) state_d = WAIT_DONE;
         WAIT_DONE: if (done_rise) state_d = retry ? ISSUE : RESP;
         RESP:      if (rsp_ready) state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end
   // Master request latched at pop, response latched on the done edge in WAIT_DONE
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         m_op_q     <= 1'b0;
         m_addr_q   <= '0;
         m_din_q    <= '0;
         rsp_op_q   <= 1'b0;
         rsp_data_q <= '0;
         rsp_err_q  <= 1'b0;
      end else begin
         if (pop) {m_op_q, m_addr_q, m_din_q} <= mem_q[rd_ptr_q];
         if (state_q == WAIT_DONE && done_rise) begin
            rsp_op_q   <= m_op_q;
            rsp_data_q <= m_op_q ? m_dout : 8'h00;
            rsp_err_q  <= m_ack_err;
         end
      end
endmodule

// File: tb/tb_i2c_cmd_queue.sv
// tb_i2c_cmd_queue: randomized bench with a scripted slave and an in-order response scoreboard
module tb_i2c_cmd_queue;
   localparam int DEPTH = 4;
   localparam int RETRY_MAX = 2;
   typedef struct {
      logic       op;
      logic [6:0] addr;
      logic [7:0] data;
      int         nack;
      logic [7:0] dout;
      int         stretch;
   } cmd_t;
   logic clk = 1'b0, rst = 1'b0;
   logic cmd_valid = 1'b0, cmd_ready, cmd_op = 1'b0;
   logic [6:0] cmd_addr = '0;
   logic [7:0] cmd_data = '0;
   logic rsp_valid, rsp_ready = 1'b0, rsp_op, rsp_err;
   logic [7:0] rsp_data;
   logic m_newd, m_op, m_busy = 1'b0, m_ack_err = 1'b0, m_done = 1'b0;
   logic [6:0] m_addr;
   logic [7:0] m_din, m_dout = '0;
   logic [$clog2(DEPTH):0] q_count;
   logic idle;
   int n_vec = 0, n_err = 0;
   int rdy_mode = 2;
   logic slave_en = 1'b1;
   cmd_t slave_q[$], rsp_q[$];
   int issues_q[$];
   i2c_cmd_queue #(.DEPTH(DEPTH), .RETRY_MAX(RETRY_MAX)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_addr(cmd_addr), .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_op(rsp_op), .rsp_data(rsp_data), .rsp_err(rsp_err), .m_newd(m_newd), .m_op(m_op),
      .m_addr(m_addr), .m_din(m_din), .m_dout(m_dout), .m_busy(m_busy), .m_ack_err(m_ack_err),
      .m_done(m_done), .q_count(q_count), .idle(idle)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   function automatic int exp_att(input int nack);
`ifdef I2C_RETRY_EN
      return (nack < RETRY_MAX ? nack : RETRY_MAX) + 1;
`else
      return 1;
`endif
   endfunction
   function automatic cmd_t mk(input logic op, input logic [6:0] addr, input logic [7:0] data,
                               input int nack, input logic [7:0] dout, input int stretch);
      cmd_t c;
      c.op = op; c.addr = addr; c.data = data; c.nack = nack; c.dout = dout; c.stretch = stretch;
      return c;
   endfunction
   task automatic push(input cmd_t c);
      logic acc;
      cmd_op = c.op; cmd_addr = c.addr; cmd_data = c.data; cmd_valid = 1'b1;
      acc = cmd_ready;
      @(negedge clk);
      cmd_valid = 1'b0;
      if (acc) begin
         slave_q.push_back(c);
         rsp_q.push_back(c);
      end
   endtask
   task automatic drain();
      for (int i = 0; i < 20000 && (rsp_q.size() != 0 || !idle); i++) @(negedge clk);
      chk("drain_pending", rsp_q.size(), 0);
      chk("drain_idle", idle, 1);
   endtask
   task automatic run(input cmd_t c);
      push(c);
      drain();
   endtask
   // Slave: each issue is checked against the queue head and answered per its plan
   initial begin
      int att = 0;
      logic bad;
      cmd_t c;
      forever begin
         @(negedge clk);
         if (slave_en && rst && m_newd) begin
            if (slave_q.size() == 0) chk("issue_spurious", 1, 0);
            else begin
               c = slave_q[0];
               att++;
               chk("m_op", m_op, c.op);
               chk("m_addr", m_addr, c.addr);
               if (!c.op) chk("m_din", m_din, c.data);
               repeat ($urandom_range(0, 2)) @(negedge clk);
               chk("newd_hold", m_newd, 1);
               m_busy = 1'b1;
               bad = 1'b0;
               repeat (c.stretch) begin
                  @(negedge clk);
                  bad |= m_newd;
               end
               chk("newd_in_busy", bad, 0);
               m_busy = 1'b0; m_done = 1'b1; m_ack_err = att <= c.nack; m_dout = c.dout;
               @(negedge clk);
               m_done = 1'b0;
               if (!m_ack_err || att == exp_att(c.nack)) begin
                  void'(slave_q.pop_front());
                  issues_q.push_back(att);
                  att = 0;
               end
            end
         end
      end
   end
   // Response collector with selectable backpressure
   initial begin
      cmd_t c;
      int n;
      forever begin
         @(negedge clk);
         rsp_ready = rdy_mode == 2 ? 1'b1 : rdy_mode == 1 ? 1'($urandom_range(0, 1)) : 1'b0;
         if (rst && rsp_valid && rsp_ready) begin
            if (rsp_q.size() == 0) chk("rsp_spurious", 1, 0);
            else begin
               c = rsp_q.pop_front();
               n = issues_q.size() != 0 ? issues_q.pop_front() : -1;
               chk("rsp_op", rsp_op, c.op);
               chk("rsp_data", rsp_data, c.op ? c.dout : 8'h00);
               chk("rsp_err", rsp_err, c.nack >= exp_att(c.nack));
               chk("issue_count", n, exp_att(c.nack));
            end
         end
      end
   end
   initial begin
      cmd_t c;
      repeat (3) @(negedge clk);
      chk("rst_newd", m_newd, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_err", rsp_err, 0);
      chk("rst_rsp_op", rsp_op, 0);
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_m_op", m_op, 0);
      chk("rst_m_addr", m_addr, 0);
      chk("rst_m_din", m_din, 0);
      chk("rst_idle", idle, 1);
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_q_count", q_count, 0);
      rst = 1'b1;
      @(negedge clk);
      slave_en = 1'b0;
      push(mk(1'b0, 7'h11, 8'h22, 0, 8'h00, 1));
      push(mk(1'b1, 7'h12, 8'h00, 0, 8'h33, 1));
      push(mk(1'b0, 7'h13, 8'h44, 0, 8'h00, 1));
      for (int i = 0; i < 20 && !m_newd; i++) @(negedge clk);
      chk("pre_rst_newd", m_newd, 1);
      chk("pre_rst_q_count", q_count, 2);
      rst = 1'b0;
      #1;
      chk("mid_rst_newd", m_newd, 0);
      chk("mid_rst_q_count", q_count, 0);
      chk("mid_rst_idle", idle, 1);
      chk("mid_rst_m_addr", m_addr, 0);
      @(posedge clk);
      #1;
      chk("mid_rst_idle_edge", idle, 1);
      chk("mid_rst_ready_edge", cmd_ready, 1);
      slave_q.delete(); rsp_q.delete(); issues_q.delete();
      @(negedge clk);
      rst = 1'b1;
      slave_en = 1'b1;
      @(negedge clk);
      run(mk(1'b0, 7'd5, 8'd3, 0, 8'h00, 3));
      run(mk(1'b1, 7'd7, 8'h5A, 0, 8'hA5, 2));
      run(mk(1'b0, 7'h2C, 8'h81, 0, 8'h00, 1200));
      run(mk(1'b0, 7'h3E, 8'h0F, 99, 8'h00, 2));
      run(mk(1'b1, 7'h40, 8'h00, 1, 8'h6C, 2));
      rdy_mode = 0;
      push(mk(1'b1, 7'h01, 8'h00, 0, 8'hC3, 1));
      for (int i = 0; i < 200 && !rsp_valid; i++) @(negedge clk);
      chk("fill_rsp_stall", rsp_valid, 1);
      for (int i = 0; i <= DEPTH; i++) begin
         chk("fill_cmd_ready", cmd_ready, i < DEPTH);
         push(mk(1'($urandom_range(0, 1)), 7'(i + 8'h20), 8'(i * 8'h11), 0, 8'(8'hB0 + i), 2));
      end
      chk("fill_q_count", q_count, DEPTH);
      chk("fill_ready_low", cmd_ready, 0);
      rdy_mode = 2;
      drain();
      rdy_mode = 1;
      for (int k = 0; k < 40; k++) begin
         repeat ($urandom_range(0, 2)) @(negedge clk);
         for (int i = 0; i < 500 && !cmd_ready; i++) @(negedge clk);
         c = mk(1'($urandom_range(0, 1)), 7'($urandom), 8'($urandom),
                $urandom_range(0, 3) == 0 ? int'($urandom_range(1, 3)) : 0,
                8'($urandom), int'($urandom_range(1, 6)));
         push(c);
      end
      rdy_mode = 2;
      drain();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
